// File: rtl/pixel_plot_sink.sv
// pixel_plot_sink: buffers plot commands from drawing FSMs, clips off-screen
// pixels, converts (x,y) to a linear framebuffer address and drains them to
// a memory write port. Also runs a full-screen clear sweep on request.
module pixel_plot_sink #(
   parameter int FIFO_DEPTH = 8,
   parameter int WIDTH      = 160,
   parameter int HEIGHT     = 120
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        plot,
   input  logic [7:0]  x,
   input  logic [6:0]  y,
   input  logic [2:0]  colour,
   output logic        ready,
   input  logic        clear,
   input  logic [2:0]  clear_colour,
   output logic        wr_en,
   output logic [14:0] wr_addr,
   output logic [2:0]  wr_data,
   input  logic        mem_ready,
   output logic        busy,
   output logic        overflow,
   output logic [7:0]  clip_count
);

   localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW    = PW + 1;
   localparam int TOTAL = WIDTH * HEIGHT;
   localparam logic [14:0] LAST_ADDR = 15'(TOTAL - 1);

   typedef enum logic {S_DRAIN, S_CLEAR} state_t;

   // FIFO entry: {addr[14:0], colour[2:0]}
   logic [17:0]   fifo_q [FIFO_DEPTH];
   logic [17:0]   fifo_d [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   state_t        state_q, state_d;
   logic          clear_pending_q, clear_pending_d;
   logic [2:0]    clr_col_q, clr_col_d;
   logic [14:0]   clr_addr_q, clr_addr_d;

   logic          wr_en_q, wr_en_d;
   logic [14:0]   wr_addr_q, wr_addr_d;
   logic [2:0]    wr_data_q, wr_data_d;

   logic          overflow_q, overflow_d;
   logic [7:0]    clip_q, clip_d;

   logic          ready_w, in_range, push, pop, out_free;
   logic [14:0]   pix_addr;
   logic [17:0]   head;

   // Handshake and address arithmetic; ready depends on registers only.
   always_comb begin
      ready_w  = (count_q < CW'(FIFO_DEPTH)) && !clear_pending_q && (state_q != S_CLEAR);
      in_range = ({1'b0, x} < 9'(WIDTH)) && ({1'b0, y} < 8'(HEIGHT));
      push     = plot && ready_w && in_range;
      pix_addr = 15'({y, 7'b0}) + 15'({y, 5'b0}) + 15'(x);
      head     = fifo_q[rd_ptr_q];
      // Output register may take new contents when empty or being accepted.
      out_free = !wr_en_q || mem_ready;
   end

   // Next-state for the drain/clear FSM and the output stage.
   always_comb begin
      state_d         = state_q;
      clear_pending_d = clear_pending_q;
      clr_col_d       = clr_col_q;
      clr_addr_d      = clr_addr_q;
      wr_en_d         = wr_en_q;
      wr_addr_d       = wr_addr_q;
      wr_data_d       = wr_data_q;
      pop             = 1'b0;
      case (state_q)
         S_DRAIN: begin
            if (clear && ready_w) begin
               clear_pending_d = 1'b1;
               clr_col_d       = clear_colour;
            end
            if (out_free) begin
               if (count_q != '0) begin
                  pop       = 1'b1;
                  wr_en_d   = 1'b1;
                  wr_addr_d = head[17:3];
                  wr_data_d = head[2:0];
               end else begin
                  wr_en_d = 1'b0;
                  // Pixels queued before the clear have all been written.
                  if (clear_pending_q) begin
                     state_d         = S_CLEAR;
                     clear_pending_d = 1'b0;
                     clr_addr_d      = '0;
                  end
               end
            end
         end
         S_CLEAR: begin
            if (out_free) begin
               if (wr_en_q && wr_addr_q == LAST_ADDR) begin
                  wr_en_d = 1'b0;
                  state_d = S_DRAIN;
               end else begin
                  wr_en_d    = 1'b1;
                  wr_addr_d  = clr_addr_q;
                  wr_data_d  = clr_col_q;
                  clr_addr_d = clr_addr_q + 15'd1;
               end
            end
         end
         default: state_d = S_DRAIN;
      endcase
   end

   // FIFO bookkeeping; simultaneous push and pop keeps count unchanged.
   always_comb begin
      fifo_d   = fifo_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         fifo_d[wr_ptr_q] = {pix_addr, colour};
         wr_ptr_d         = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Status flags: sticky drop indicator and saturating clip counter.
   always_comb begin
      overflow_d = overflow_q | (plot && !ready_w);
      clip_d     = clip_q;
      if (plot && ready_w && !in_range && clip_q != 8'hFF) clip_d = clip_q + 8'd1;
   end

   // State registers; reset discards all pending work.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         count_q         <= '0;
         state_q         <= S_DRAIN;
         clear_pending_q <= 1'b0;
         clr_col_q       <= '0;
         clr_addr_q      <= '0;
         wr_en_q         <= 1'b0;
         wr_addr_q       <= '0;
         wr_data_q       <= '0;
         overflow_q      <= 1'b0;
         clip_q          <= '0;
      end else begin
         fifo_q          <= fifo_d;
         wr_ptr_q        <= wr_ptr_d;
         rd_ptr_q        <= rd_ptr_d;
         count_q         <= count_d;
         state_q         <= state_d;
         clear_pending_q <= clear_pending_d;
         clr_col_q       <= clr_col_d;
         clr_addr_q      <= clr_addr_d;
         wr_en_q         <= wr_en_d;
         wr_addr_q       <= wr_addr_d;
         wr_data_q       <= wr_data_d;
         overflow_q      <= overflow_d;
         clip_q          <= clip_d;
      end
   end

   assign ready      = ready_w;
   assign wr_en      = wr_en_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign overflow   = overflow_q;
   assign clip_count = clip_q;
   assign busy       = clear_pending_q || (state_q == S_CLEAR) || (count_q != '0) || wr_en_q;

endmodule

// File: tb/tb_pixel_plot_sink.sv
// Directed bench for pixel_plot_sink: single pixel, clipping, backpressure,
// clear ordering with a mid-sweep stall, and reset in the middle of a clear.
module tb_pixel_plot_sink;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        plot = 1'b0;
   logic [7:0]  x = '0;
   logic [6:0]  y = '0;
   logic [2:0]  colour = '0;
   logic        ready;
   logic        clear = 1'b0;
   logic [2:0]  clear_colour = '0;
   logic        wr_en;
   logic [14:0] wr_addr;
   logic [2:0]  wr_data;
   logic        mem_ready = 1'b1;
   logic        busy;
   logic        overflow;
   logic [7:0]  clip_count;

   int checks = 0;
   int failures = 0;
   int log_addr[$];
   int log_data[$];

   pixel_plot_sink #(.FIFO_DEPTH(8), .WIDTH(160), .HEIGHT(120)) dut (
      .clk(clk), .reset(reset), .plot(plot), .x(x), .y(y), .colour(colour),
      .ready(ready), .clear(clear), .clear_colour(clear_colour),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .mem_ready(mem_ready), .busy(busy), .overflow(overflow),
      .clip_count(clip_count)
   );

   always #5 clk = ~clk;

   // Inputs only change just after the rising edge, so a write seen here is
   // the one memory accepts on the next rising edge.
   always @(negedge clk) begin
      if (!reset && wr_en && mem_ready) begin
         log_addr.push_back(int'(wr_addr));
         log_data.push_back(int'(wr_data));
      end
   end

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic set_px(input int px, input int py, input int pc);
      x      = 8'(px);
      y      = 7'(py);
      colour = 3'(pc);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ready"}, int'(ready), 1);
      chk({tag, "_wr_en"}, int'(wr_en), 0);
      chk({tag, "_wr_addr"}, int'(wr_addr), 0);
      chk({tag, "_wr_data"}, int'(wr_data), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_overflow"}, int'(overflow), 0);
      chk({tag, "_clip"}, int'(clip_count), 0);
   endtask

   initial begin
      int bad;
      int n;
      bit stalled;

      do_reset();
      chk_reset_vals("rst");

      // Single pixel: (5,3) -> 3*160+5 = 485
      log_addr.delete(); log_data.delete();
      set_px(5, 3, 4); plot = 1'b1;
      tick();
      plot = 1'b0;
      chk("px_lat_n", int'(wr_en), 0);
      tick();
      chk("px_wr_en", int'(wr_en), 1);
      chk("px_addr", int'(wr_addr), 485);
      chk("px_data", int'(wr_data), 4);
      tick();
      chk("px_done_wr_en", int'(wr_en), 0);
      chk("px_busy", int'(busy), 0);
      repeat (3) tick();
      chk("px_nwrites", log_addr.size(), 1);

      // Clipping
      log_addr.delete(); log_data.delete();
      plot = 1'b1;
      set_px(160, 0, 1);   tick();
      set_px(0, 120, 2);   tick();
      set_px(159, 119, 3); tick();
      plot = 1'b0;
      repeat (4) tick();
      chk("clip_count", int'(clip_count), 2);
      chk("clip_nwrites", log_addr.size(), 1);
      if (log_addr.size() > 0) chk("clip_addr", log_addr[0], 19199);
      chk("clip_overflow", int'(overflow), 0);

      // Backpressure: 8 in FIFO + 1 in output stage
      log_addr.delete(); log_data.delete();
      mem_ready = 1'b0;
      bad = 0;
      for (int i = 0; i < 9; i++) begin
         if (!ready) bad++;
         set_px(i, 0, i % 8); plot = 1'b1;
         tick();
      end
      plot = 1'b0;
      chk("bp_ready_before", bad, 0);
      chk("bp_ready_full", int'(ready), 0);
      chk("bp_busy", int'(busy), 1);
      set_px(20, 0, 7); plot = 1'b1;
      tick();
      plot = 1'b0;
      chk("bp_overflow", int'(overflow), 1);
      chk("bp_hold_en", int'(wr_en), 1);
      chk("bp_hold_addr", int'(wr_addr), 0);
      mem_ready = 1'b1;
      repeat (15) tick();
      chk("bp_nwrites", log_addr.size(), 9);
      bad = 0;
      for (int i = 0; i < log_addr.size() && i < 9; i++)
         if (log_addr[i] != i || log_data[i] != i % 8) bad++;
      chk("bp_order", bad, 0);
      chk("bp_overflow_sticky", int'(overflow), 1);
      chk("bp_idle", int'(busy), 0);

      // Clear ordering with a 5-cycle stall at address 100
      do_reset();
      log_addr.delete(); log_data.delete();
      mem_ready = 1'b1;
      plot = 1'b1;
      set_px(10, 2, 7); tick();
      set_px(11, 2, 6); tick();
      set_px(12, 2, 5); clear = 1'b1; clear_colour = 3'b001; tick();
      plot = 1'b0; clear = 1'b0; clear_colour = 3'b000;
      chk("clr_ready_low", int'(ready), 0);
      bad = 0; n = 0; stalled = 1'b0;
      while (busy && n < 25000) begin
         if (ready) bad++;
         if (!stalled && wr_en && wr_addr == 15'd100 && wr_data == 3'd1) begin
            stalled = 1'b1;
            mem_ready = 1'b0;
            for (int k = 0; k < 5; k++) begin
               tick();
               if (!(wr_en && wr_addr == 15'd100)) bad++;
            end
            mem_ready = 1'b1;
         end
         tick();
         n++;
      end
      chk("clr_timeout", int'(n < 25000), 1);
      chk("clr_ready_during", bad, 0);
      chk("clr_stall_seen", int'(stalled), 1);
      chk("clr_ready_after", int'(ready), 1);
      chk("clr_busy_after", int'(busy), 0);
      chk("clr_nwrites", log_addr.size(), 3 + 19200);
      if (log_addr.size() >= 3) begin
         chk("clr_px0", log_addr[0] * 8 + log_data[0], 330 * 8 + 7);
         chk("clr_px1", log_addr[1] * 8 + log_data[1], 331 * 8 + 6);
         chk("clr_px2", log_addr[2] * 8 + log_data[2], 332 * 8 + 5);
      end
      bad = 0;
      for (int i = 3; i < log_addr.size(); i++)
         if (log_addr[i] != i - 3 || log_data[i] != 1) bad++;
      chk("clr_sweep_seq", bad, 0);

      // Reset in the middle of a clear sweep
      log_addr.delete(); log_data.delete();
      clear = 1'b1; clear_colour = 3'b010;
      tick();
      clear = 1'b0;
      n = 0;
      while (!(wr_en && wr_addr == 15'd5000) && n < 8000) begin
         tick();
         n++;
      end
      chk("mid_timeout", int'(n < 8000), 1);
      reset = 1'b1;
      #1;
      chk_reset_vals("mid_rst");
      tick();
      reset = 1'b0;
      tick();
      log_addr.delete(); log_data.delete();
      set_px(1, 1, 2); plot = 1'b1;
      tick();
      plot = 1'b0;
      repeat (4) tick();
      chk("post_rst_nwrites", log_addr.size(), 1);
      if (log_addr.size() > 0) begin
         chk("post_rst_addr", log_addr[0], 161);
         chk("post_rst_data", log_data[0], 2);
      end
      chk("post_rst_idle", int'(busy), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
